// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding one UART transmitter and baud generator.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (12-tick frame).
module uart_tx_sched #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  input  logic                   clk_bps,
  output logic [NREQ-1:0]        ack,
  output logic                   done,
  output logic                   busy,
  output logic                   bps_start,
  output logic                   txd
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] LAST = 4'd12;
`else
  localparam logic [3:0] LAST = 4'd11;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [LW-1:0] last_q, last_d, win;
  logic [NREQ-1:0] ack_q, ack_d;
  logic done_q, done_d, busy_q, busy_d, bps_q, bps_d, txd_q, txd_d, par_bit;
`ifdef UART_TX_PARITY_EN
  assign par_bit = ^byte_q;
`else
  assign par_bit = 1'b1;
`endif
  // Scan from the farthest candidate back so the one nearest last_q+1 wins.
  always_comb begin
    win = last_q;
    for (int k = NREQ; k >= 1; k--)
      if (req[LW'((int'(last_q) + k) % NREQ)]) win = LW'((int'(last_q) + k) % NREQ);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    byte_d = byte_q;
    last_d = last_q;
    ack_d = '0;
    done_d = 1'b0;
    busy_d = busy_q;
    bps_d = bps_q;
    txd_d = txd_q;
    if (state_q == IDLE) begin
      busy_d = 1'b0;
      if (|req) begin
        state_d = SEND;
        cnt_d = '0;
        byte_d = DATA_W'(data >> (DATA_W * int'(win)));
        last_d = win;
        ack_d = NREQ'(1) << win;
        busy_d = 1'b1;
        bps_d = 1'b1;
        txd_d = 1'b1;
      end
    end else if (clk_bps) begin
      cnt_d = cnt_q + 4'd1;
      txd_d = (cnt_d == 4'd1) ? 1'b0 :
              (cnt_d <= 4'd9) ? byte_q[3'(cnt_d - 4'd2)] :
              (cnt_d == 4'd10) ? par_bit : 1'b1;
      // busy holds through the done cycle and drops on the following edge
      if (cnt_d == LAST) begin
        state_d = IDLE;
        cnt_d = '0;
        done_d = 1'b1;
        bps_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      last_q <= LW'(NREQ - 1);
      ack_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      bps_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      last_q <= last_d;
      ack_q <= ack_d;
      done_q <= done_d;
      busy_q <= busy_d;
      bps_q <= bps_d;
      txd_q <= txd_d;
    end
  end
  assign ack = ack_q;
  assign done = done_q;
  assign busy = busy_q;
  assign bps_start = bps_q;
  assign txd = txd_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench for uart_tx_sched with a behavioural
// baud generator; build with UART_TX_PARITY_EN to check the parity frame.
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int P = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 12;
`else
  localparam int FL = 11;
`endif
  typedef struct {int idx; logic [7:0] b;} exp_t;
  logic clk = 1'b0, rst_n, clk_bps;
  logic [NREQ-1:0] req, ack;
  logic [NREQ*8-1:0] data;
  logic done, busy, bps_start, txd;
  int n_cmp = 0, n_err = 0;
  exp_t exp_q[$];
  int last_g;
  bit in_frame = 0, gap_chk = 0;
  int ticks = 0, cyc = 0, done_cyc = 0;
  logic cur = 1'b1;
  logic [FL-2:0] fr;

  uart_tx_sched #(.NREQ(NREQ), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .clk_bps(clk_bps),
    .ack(ack), .done(done), .busy(busy), .bps_start(bps_start), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame bits in transmit order, LSB = start bit.
  function automatic logic [FL-2:0] frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  function automatic int rr(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ*8-1:0] rand_data();
    logic [NREQ*8-1:0] d;
    d = '0;
    for (int i = 0; i < NREQ; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  task automatic push_exp(input logic [NREQ-1:0] m, input logic [NREQ*8-1:0] d);
    exp_t e;
    last_g = rr(m);
    e.idx = last_g;
    e.b = d[8*last_g +: 8];
    exp_q.push_back(e);
  endtask

  task automatic txn_start(input logic [NREQ-1:0] m, input logic [NREQ*8-1:0] d);
    int n;
    @(negedge clk);
    data = d;
    req = m;
    push_exp(m, d);
    n = 0;
    while (ack == '0 && n < 20) begin @(negedge clk); n++; end
    chk("ack_wait", n < 20, 1);
    req = '0;
  endtask

  task automatic txn(input logic [NREQ-1:0] m, input logic [NREQ*8-1:0] d);
    int n;
    txn_start(m, d);
    n = 0;
    while (!done && n < FL*P*2) begin @(negedge clk); n++; end
    chk("done_wait", n < FL*P*2, 1);
  endtask

  task automatic held(input logic [NREQ-1:0] m, input logic [NREQ*8-1:0] d, input int k);
    int nd, n;
    @(negedge clk);
    data = d;
    req = m;
    for (int i = 0; i < k; i++) push_exp(m, d);
    nd = 0;
    n = 0;
    while (nd < k && n < k*FL*P*2) begin
      @(negedge clk);
      n++;
      if (ack != '0) gap_chk = 1;
      if (done) begin
        nd++;
        if (nd == k) req = '0;
      end
    end
    chk("held_frames", nd, k);
    gap_chk = 0;
  endtask

  // Baud generator: cleared while bps_start is low, tick mid-bit; random stray ticks when idle.
  initial begin
    int c;
    c = 0;
    clk_bps = 1'b0;
    forever begin
      @(negedge clk);
      if (bps_start) begin
        c = (c == P-1) ? 0 : c + 1;
        clk_bps = (c == P/2);
      end else begin
        c = 0;
        clk_bps = ($urandom_range(0, 2) == 0);
      end
    end
  end

  initial begin
    logic tk;
    bit done_now;
    exp_t e;
    forever begin
      @(posedge clk);
      tk = clk_bps;
      cyc++;
      #1;
      if (!rst_n) begin
        in_frame = 0;
        ticks = 0;
        cur = 1'b1;
        exp_q.delete();
      end else begin
        done_now = 0;
        if (ack != '0) begin
          chk("ack_in_frame", in_frame, 0);
          if (exp_q.size() == 0) chk("ack_unexpected", ack, 0);
          else begin
            e = exp_q.pop_front();
            chk("ack_grant", ack, 1 << e.idx);
            fr = frame(e.b);
            if (gap_chk) chk("ack_gap", cyc - done_cyc, 1);
          end
          in_frame = 1;
          ticks = 0;
          cur = 1'b1;
        end else if (in_frame && tk) begin
          ticks++;
          if (ticks == FL) begin
            in_frame = 0;
            done_now = 1;
            done_cyc = cyc;
            cur = 1'b1;
          end else cur = fr[ticks-1];
        end
        chk("txd", txd, cur);
        chk("done", done, done_now);
        chk("bps_start", bps_start, in_frame);
        chk("busy", busy, in_frame || done_now);
      end
    end
  end

  initial begin
    logic [NREQ*8-1:0] d;
    int n;
    rst_n = 1'b0;
    req = '0;
    data = '0;
    last_g = NREQ - 1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bps", bps_start, 0);
    chk("rst_txd", txd, 1);
    rst_n = 1'b1;
    held(4'b1011, rand_data(), 6);
    d = rand_data();
    d[7:0] = 8'hA5;
    txn(4'b0001, d);
    held(4'b0100, rand_data(), 3);
    d = rand_data();
    d[31:24] = 8'h07;
    txn(4'b1000, d);
    d = rand_data();
    d[23:16] = 8'h3C;
    txn_start(4'b0100, d);
    n = 0;
    while (ticks < 5 && n < FL*P*2) begin @(negedge clk); n++; end
    chk("tick5_wait", n < FL*P*2, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bps", bps_start, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ack", ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_g = NREQ - 1;
    txn(4'b0010, rand_data());
    repeat (30) txn(NREQ'($urandom_range(1, 2**NREQ - 1)), rand_data());
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
